// File: rtl/mlow_codec_scheduler.sv
// Frame-granular arbiter sharing one mlow_codec core between encode and decode requesters.
// Optional macro MLOW_SCHED_DEC_PRIORITY_EN: decode strictly wins over encode instead of round-robin.
module mlow_codec_scheduler #(
  parameter int unsigned FRAME_SIZE     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned FLUSH_CYCLES   = 4
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       enc_req_i,
  input  logic       dec_req_i,
  input  logic [3:0] bitrate_sel_i,
  input  logic [1:0] bandwidth_sel_i,
  input  logic       sample_fire_i,
  input  logic       core_busy_i,
  input  logic       core_error_i,
  output logic       enc_grant_o,
  output logic       dec_grant_o,
  output logic       core_encode_mode_o,
  output logic [3:0] core_bitrate_sel_o,
  output logic [1:0] core_bandwidth_sel_o,
  output logic       core_start_o,
  output logic       core_flush_o,
  output logic       frame_done_o,
  output logic       timeout_o,
  output logic [7:0] err_count_o,
  output logic       sched_busy_o
);

  localparam int unsigned CNT_W = $clog2(FRAME_SIZE + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FL_W  = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, RECOVER} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] sample_cnt, sample_cnt_d;
  logic [WD_W-1:0]  wd_cnt, wd_cnt_d, wd_inc;
  logic [FL_W-1:0]  flush_cnt, flush_cnt_d;
  logic             last_enc, last_enc_d;
  logic             enc_grant_d, dec_grant_d, mode_d;
  logic [3:0]       bitrate_d;
  logic [1:0]       bandwidth_d;
  logic             start_d, flush_d, done_d, timeout_d;
  logic [7:0]       err_count_d;
  logic             pick_enc, wd_hit, enter_recover;

  // Winner selection when leaving IDLE
  always_comb begin
`ifdef MLOW_SCHED_DEC_PRIORITY_EN
    pick_enc = !dec_req_i;
`else
    pick_enc = enc_req_i && (!dec_req_i || !last_enc);
`endif
  end

  assign wd_inc = wd_cnt + WD_W'(1);
  assign wd_hit = (wd_inc == WD_W'(TIMEOUT_CYCLES));

  // Next-state and next-output logic
  always_comb begin
    state_d       = state;
    sample_cnt_d  = sample_cnt;
    wd_cnt_d      = wd_cnt;
    flush_cnt_d   = flush_cnt;
    last_enc_d    = last_enc;
    enc_grant_d   = enc_grant_o;
    dec_grant_d   = dec_grant_o;
    mode_d        = core_encode_mode_o;
    bitrate_d     = core_bitrate_sel_o;
    bandwidth_d   = core_bandwidth_sel_o;
    start_d       = 1'b0;
    flush_d       = 1'b0;
    done_d        = 1'b0;
    timeout_d     = 1'b0;
    err_count_d   = err_count_o;
    enter_recover = 1'b0;

    case (state)
      IDLE: begin
        if (enc_req_i || dec_req_i) begin
          state_d     = START;
          enc_grant_d = pick_enc;
          dec_grant_d = !pick_enc;
          mode_d      = pick_enc;
          bitrate_d   = bitrate_sel_i;
          bandwidth_d = bandwidth_sel_i;
          start_d     = 1'b1;
        end
      end
      START: begin
        sample_cnt_d = '0;
        wd_cnt_d     = '0;
        if (core_error_i) enter_recover = 1'b1;
        else              state_d = RUN;
      end
      RUN: begin
        if (core_error_i) begin
          enter_recover = 1'b1;
        end else if (wd_hit) begin
          timeout_d     = 1'b1;
          enter_recover = 1'b1;
        end else if (sample_fire_i) begin
          sample_cnt_d = sample_cnt + CNT_W'(1);
          wd_cnt_d     = '0;
          if (sample_cnt + CNT_W'(1) == CNT_W'(FRAME_SIZE)) state_d = DRAIN;
        end else begin
          wd_cnt_d = wd_inc;
        end
      end
      DRAIN: begin
        if (core_error_i) begin
          enter_recover = 1'b1;
        end else if (wd_hit) begin
          timeout_d     = 1'b1;
          enter_recover = 1'b1;
        end else if (!core_busy_i) begin
          done_d      = 1'b1;
          last_enc_d  = core_encode_mode_o;
          enc_grant_d = 1'b0;
          dec_grant_d = 1'b0;
          state_d     = IDLE;
        end else begin
          wd_cnt_d = wd_inc;
        end
      end
      RECOVER: begin
        if (flush_cnt == FL_W'(FLUSH_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          flush_d     = 1'b1;
          flush_cnt_d = flush_cnt + FL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Recovery entry: drop grants, start flushing, blame the failed path
    if (enter_recover) begin
      state_d     = RECOVER;
      enc_grant_d = 1'b0;
      dec_grant_d = 1'b0;
      flush_d     = 1'b1;
      flush_cnt_d = '0;
      last_enc_d  = core_encode_mode_o;
      if (err_count_o != 8'hFF) err_count_d = err_count_o + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state                <= IDLE;
      sample_cnt           <= '0;
      wd_cnt               <= '0;
      flush_cnt            <= '0;
      last_enc             <= 1'b0;
      enc_grant_o          <= 1'b0;
      dec_grant_o          <= 1'b0;
      core_encode_mode_o   <= 1'b0;
      core_bitrate_sel_o   <= '0;
      core_bandwidth_sel_o <= '0;
      core_start_o         <= 1'b0;
      core_flush_o         <= 1'b0;
      frame_done_o         <= 1'b0;
      timeout_o            <= 1'b0;
      err_count_o          <= '0;
      sched_busy_o         <= 1'b0;
    end else begin
      state                <= state_d;
      sample_cnt           <= sample_cnt_d;
      wd_cnt               <= wd_cnt_d;
      flush_cnt            <= flush_cnt_d;
      last_enc             <= last_enc_d;
      enc_grant_o          <= enc_grant_d;
      dec_grant_o          <= dec_grant_d;
      core_encode_mode_o   <= mode_d;
      core_bitrate_sel_o   <= bitrate_d;
      core_bandwidth_sel_o <= bandwidth_d;
      core_start_o         <= start_d;
      core_flush_o         <= flush_d;
      frame_done_o         <= done_d;
      timeout_o            <= timeout_d;
      err_count_o          <= err_count_d;
      sched_busy_o         <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_mlow_codec_scheduler.sv
// Randomized frame-level bench for mlow_codec_scheduler against a transaction-level model.
module tb_mlow_codec_scheduler;

  localparam int unsigned FS = 16;
  localparam int unsigned TO = 32;
  localparam int unsigned FL = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enc_req, dec_req, sample_fire, core_busy, core_error;
  logic [3:0] bitrate;
  logic [1:0] bandwidth;
  logic       enc_grant, dec_grant, core_mode, core_start, core_flush;
  logic       frame_done, timeout, sched_busy;
  logic [3:0] core_br;
  logic [1:0] core_bw;
  logic [7:0] err_count;

  mlow_codec_scheduler #(.FRAME_SIZE(FS), .TIMEOUT_CYCLES(TO), .FLUSH_CYCLES(FL)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .enc_req_i(enc_req), .dec_req_i(dec_req),
    .bitrate_sel_i(bitrate), .bandwidth_sel_i(bandwidth),
    .sample_fire_i(sample_fire), .core_busy_i(core_busy), .core_error_i(core_error),
    .enc_grant_o(enc_grant), .dec_grant_o(dec_grant), .core_encode_mode_o(core_mode),
    .core_bitrate_sel_o(core_br), .core_bandwidth_sel_o(core_bw),
    .core_start_o(core_start), .core_flush_o(core_flush), .frame_done_o(frame_done),
    .timeout_o(timeout), .err_count_o(err_count), .sched_busy_o(sched_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  bit model_last_enc = 1'b0;
  int model_err = 0;
  int exp_starts = 0, exp_dones = 0;
  int starts = 0, dones = 0, timeouts = 0;
  bit both_seen = 1'b0;
  bit winner_obs;
  logic [3:0] served;

  // Pulse counters and the mutual-exclusion watch
  always @(negedge clk) begin
    if (enc_grant && dec_grant) both_seen = 1'b1;
    if (core_start) starts++;
    if (frame_done) dones++;
    if (timeout)    timeouts++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit pick(input bit e, input bit d);
    if (e && d) begin
`ifdef MLOW_SCHED_DEC_PRIORITY_EN
      return 1'b0;
`else
      return model_last_enc ? 1'b0 : 1'b1;
`endif
    end
    return e;
  endfunction

  task automatic recover_check(input bit we);
    model_err      = (model_err < 255) ? model_err + 1 : 255;
    model_last_enc = we;
    check("rec_flush_entry", core_flush, 1);
    check("rec_grants", {enc_grant, dec_grant}, 0);
    check("rec_no_done", frame_done, 0);
    check("rec_err_count", err_count, model_err);
    for (int k = 1; k < FL; k++) begin
      tick();
      check("rec_flush_hold", core_flush, 1);
      check("rec_timeout_low", timeout, 0);
    end
    tick();
    check("rec_flush_end", core_flush, 0);
    check("rec_idle", sched_busy, 0);
  endtask

  // mode: 0 clean, 1 error on last fire, 2 watchdog after stop_after fires, 3 error at drain end
  task automatic do_frame(input bit e, input bit d, input logic [3:0] br, input logic [3:0] br_mid,
                          input logic [1:0] bw, input int mode, input int tail, input int stop_after);
    bit we;
    int nf, gap;
    enc_req = e; dec_req = d; bitrate = br; bandwidth = bw;
    core_busy = 1'b1; sample_fire = 1'b0; core_error = 1'b0;
    we = pick(e, d);
    tick();
    winner_obs = enc_grant;
    check("grant_enc", enc_grant, we);
    check("grant_dec", dec_grant, !we);
    check("enc_mode", core_mode, we);
    check("cfg_br", core_br, br);
    check("cfg_bw", core_bw, bw);
    check("start_high", core_start, 1);
    check("busy_high", sched_busy, 1);
    exp_starts++;
    bitrate = br_mid; bandwidth = ~bw;
    if ($urandom_range(1) == 1) begin enc_req = 1'b0; dec_req = 1'b0; end
    sample_fire = 1'($urandom_range(1));
    tick();
    check("start_single", core_start, 0);
    check("grant_held", we ? enc_grant : dec_grant, 1);
    nf = (mode == 2) ? stop_after : FS;
    for (int i = 0; i < nf; i++) begin
      gap = $urandom_range(2);
      for (int g = 0; g < gap; g++) begin sample_fire = 1'b0; tick(); end
      sample_fire = 1'b1;
      core_error  = (mode == 1 && i == nf - 1);
      tick();
      check("cfg_hold_br", core_br, br);
      check("cfg_hold_bw", core_bw, bw);
      if (i < nf - 1 || mode == 0 || mode == 3) check("run_grant", we ? enc_grant : dec_grant, 1);
    end
    sample_fire = 1'b0; core_error = 1'b0;
    if (mode == 0 || mode == 3) begin
      for (int k = 0; k < tail; k++) begin
        tick();
        check("drain_no_done", frame_done, 0);
      end
      core_busy = 1'b0;
      core_error = (mode == 3);
      tick();
      core_error = 1'b0;
      if (mode == 0) begin
        check("frame_done", frame_done, 1);
        check("done_grants", {enc_grant, dec_grant}, 0);
        check("done_idle", sched_busy, 0);
        model_last_enc = we;
        exp_dones++;
      end else begin
        recover_check(we);
      end
    end else if (mode == 1) begin
      recover_check(we);
    end else begin
      for (int k = 1; k < TO; k++) begin
        tick();
        if (k == TO - 1) check("timeout_early", timeout, 0);
      end
      tick();
      check("timeout_fire", timeout, 1);
      recover_check(we);
    end
    enc_req = 1'b0; dec_req = 1'b0; core_busy = 1'b0;
  endtask

  task automatic quick_err(input bit e, input bit d);
    bit we;
    enc_req = e; dec_req = d;
    we = pick(e, d);
    tick();
    check("qe_grant", enc_grant, we);
    exp_starts++;
    core_error = 1'b1; enc_req = 1'b0; dec_req = 1'b0;
    tick();
    core_error = 1'b0;
    recover_check(we);
  endtask

  initial begin
    reset_n = 1'b0;
    enc_req = 0; dec_req = 0; sample_fire = 0; core_busy = 0; core_error = 0;
    bitrate = 0; bandwidth = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {enc_grant, dec_grant, core_mode, core_br, core_bw, core_start,
                            core_flush, frame_done, timeout, err_count, sched_busy}, 0);
    @(negedge clk) reset_n = 1'b1;
    tick();

    served = '0;
    for (int f = 0; f < 4; f++) begin
      do_frame(1, 1, 4'(f), 4'(f + 1), 2'(f), 0, $urandom_range(3), 0);
      served = {served[2:0], winner_obs};
    end
`ifdef MLOW_SCHED_DEC_PRIORITY_EN
    check("rr_order", served, 4'b0000);
`else
    check("rr_order", served, 4'b1010);
`endif

    do_frame(1, 0, 4'd3, 4'd7, 2'd1, 0, 3, 0);
    do_frame(1, 0, 4'd5, 4'd9, 2'd2, 0, 1, 0);
    do_frame(1, 0, 4'd9, 4'd2, 2'd0, 0, 0, 0);

    do_frame(1, 0, 4'd1, 4'd1, 2'd1, 2, 0, 10);
    do_frame(1, 1, 4'd2, 4'd2, 2'd2, 0, 2, 0);
    check("after_timeout_dec", winner_obs, 0);

    do_frame(0, 1, 4'd6, 4'd6, 2'd3, 1, 0, 0);
    do_frame(1, 0, 4'd4, 4'd8, 2'd0, 3, 2, 0);

    for (int r = 0; r < 30; r++) begin
      bit e, d;
      int m;
      e = 1'($urandom_range(1));
      d = e ? 1'($urandom_range(1)) : 1'b1;
      case ($urandom_range(2))
        0: m = 0;
        1: m = 1;
        default: m = 3;
      endcase
      do_frame(e, d, 4'($urandom), 4'($urandom), 2'($urandom), m, $urandom_range(4), 0);
    end

    for (int q = 0; q < 300; q++) quick_err(1'($urandom_range(1)), 1'b1);
    check("err_saturated", err_count, 255);

    enc_req = 1'b1;
    tick();
    exp_starts++;
    enc_req = 1'b0;
    for (int k = 0; k < 5; k++) begin sample_fire = 1'b1; tick(); end
    sample_fire = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {enc_grant, dec_grant, core_mode, core_br, core_bw, core_start,
                                  core_flush, frame_done, timeout, err_count, sched_busy}, 0);
    @(negedge clk) reset_n = 1'b1;
    model_last_enc = 1'b0;
    model_err      = 0;
    tick();
    do_frame(1, 1, 4'd11, 4'd12, 2'd3, 0, 1, 0);
`ifdef MLOW_SCHED_DEC_PRIORITY_EN
    check("post_reset_winner", winner_obs, 0);
`else
    check("post_reset_winner", winner_obs, 1);
`endif
    tick();

    check("no_dual_grant", both_seen, 0);
    check("start_count", starts, exp_starts);
    check("done_count", dones, exp_dones);
    check("timeout_count", timeouts, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed hang expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
